// File: rtl/sata_oob_ctrl.sv
// Host-side SATA OOB sequencer: COMRESET/COMWAKE bursts, D10.2/ALIGN handshake, then link_up.
// Restarts on response timeout, device COMINIT in READY, or sustained RX electrical idle.
module sata_oob_ctrl #(
  parameter logic [19:0] RETRY_TIMEOUT = 20'd66000,
  parameter int          LOSS_CYCLES   = 16,
  parameter int          NONALIGN_REQ  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gt_reset_done,
  input  logic        txcomfinish,
  input  logic        rxcominitdet,
  input  logic        rxcomwakedet,
  input  logic        rxelecidle,
  input  logic [31:0] rxdata,
  input  logic [3:0]  rxcharisk,
  output logic        txcominit,
  output logic        txcomwake,
  output logic        txelecidle,
  output logic [31:0] txdata,
  output logic [3:0]  txcharisk,
  output logic        data_valid,
  output logic        link_up,
  output logic [3:0]  state_o
);

  localparam logic [3:0] IDLE           = 4'd0;
  localparam logic [3:0] COMRESET       = 4'd1;
  localparam logic [3:0] WAIT_COMINIT   = 4'd2;
  localparam logic [3:0] COMWAKE        = 4'd3;
  localparam logic [3:0] WAIT_COMWAKE   = 4'd4;
  localparam logic [3:0] WAIT_NOCOMWAKE = 4'd5;
  localparam logic [3:0] WAIT_ALIGN     = 4'd6;
  localparam logic [3:0] SEND_ALIGN     = 4'd7;
  localparam logic [3:0] READY          = 4'd8;

  localparam logic [31:0] PRIM_ALIGN = 32'h7B4A4ABC;
  localparam logic [31:0] PRIM_D102  = 32'h4A4A4A4A;
  localparam logic [31:0] PRIM_SYNC  = 32'hB5B5957C;

  localparam logic [19:0] TIMEOUT_LAST = RETRY_TIMEOUT - 20'd1;
  localparam logic [15:0] NA_LAST      = 16'(NONALIGN_REQ - 1);
  localparam logic [15:0] LOSS_LAST    = 16'(LOSS_CYCLES - 1);

  logic [3:0]  state;
  logic [3:0]  state_nxt;
  logic [19:0] timer;
  logic [15:0] run_cnt;
  logic        rx_align;
  logic        timeout;

  function automatic logic is_align(input logic [31:0] data, input logic [3:0] isk);
    return (data == PRIM_ALIGN) && (isk == 4'b0001);
  endfunction

  assign rx_align = is_align(rxdata, rxcharisk);
  assign timeout  = (timer == TIMEOUT_LAST);
  assign state_o  = state;

  always_comb begin
    state_nxt = state;
    if (!gt_reset_done) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:           state_nxt = COMRESET;
        COMRESET:       if (txcomfinish) state_nxt = WAIT_COMINIT;
        WAIT_COMINIT:   if (rxcominitdet) state_nxt = COMWAKE;
                        else if (timeout) state_nxt = COMRESET;
        COMWAKE:        if (txcomfinish) state_nxt = WAIT_COMWAKE;
        WAIT_COMWAKE:   if (rxcomwakedet) state_nxt = WAIT_NOCOMWAKE;
                        else if (timeout) state_nxt = COMRESET;
        WAIT_NOCOMWAKE: if (!rxcomwakedet) state_nxt = WAIT_ALIGN;
                        else if (timeout) state_nxt = COMRESET;
        WAIT_ALIGN:     if (rx_align) state_nxt = SEND_ALIGN;
                        else if (timeout) state_nxt = COMRESET;
        // The word that completes the non-ALIGN run moves us on, so link_up lands one cycle later.
        SEND_ALIGN:     if (!rx_align && run_cnt == NA_LAST) state_nxt = READY;
                        else if (timeout) state_nxt = COMRESET;
        READY:          if (rxcominitdet || (rxelecidle && run_cnt == LOSS_LAST)) state_nxt = COMRESET;
        default:        state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      run_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) timer <= '0;
      else if (timer != '1)   timer <= timer + 20'd1;
      // Shared run counter: non-ALIGN words in SEND_ALIGN, idle cycles in READY.
      if (state_nxt != state)    run_cnt <= '0;
      else if (state == SEND_ALIGN) run_cnt <= rx_align ? '0 : run_cnt + 16'd1;
      else if (state == READY)      run_cnt <= rxelecidle ? run_cnt + 16'd1 : '0;
      else                          run_cnt <= '0;
    end
  end

  // Outputs are decoded from the next state so they line up with state_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txcominit  <= 1'b0;
      txcomwake  <= 1'b0;
      txelecidle <= 1'b1;
      txdata     <= '0;
      txcharisk  <= '0;
      data_valid <= 1'b0;
      link_up    <= 1'b0;
    end else begin
      txcominit  <= (state_nxt == COMRESET) && (state != COMRESET);
      txcomwake  <= (state_nxt == COMWAKE) && (state != COMWAKE);
      txelecidle <= !((state_nxt == WAIT_ALIGN) || (state_nxt == SEND_ALIGN) || (state_nxt == READY));
      data_valid <= (state_nxt == READY);
      link_up    <= (state_nxt == READY);
      case (state_nxt)
        WAIT_ALIGN: begin txdata <= PRIM_D102;  txcharisk <= 4'b0000; end
        SEND_ALIGN: begin txdata <= PRIM_ALIGN; txcharisk <= 4'b0001; end
        READY:      begin txdata <= PRIM_SYNC;  txcharisk <= 4'b0001; end
        default:    begin txdata <= '0;         txcharisk <= 4'b0000; end
      endcase
    end
  end

endmodule

// File: tb/tb_sata_oob_ctrl.sv
// Directed bench for sata_oob_ctrl: table-driven handshake walk plus hand sequences for
// retry timeout, link loss, ALIGN interruption, async reset and coincident exit events.
module tb_sata_oob_ctrl;

  localparam logic [31:0] ALIGN = 32'h7B4A4ABC;
  localparam logic [31:0] D102  = 32'h4A4A4A4A;
  localparam logic [31:0] SYNC  = 32'hB5B5957C;

  logic        clk = 1'b0;
  logic        rst;
  logic        gt_reset_done, txcomfinish, rxcominitdet, rxcomwakedet, rxelecidle;
  logic [31:0] rxdata;
  logic [3:0]  rxcharisk;
  logic        txcominit, txcomwake, txelecidle, data_valid, link_up;
  logic [31:0] txdata;
  logic [3:0]  txcharisk, state_o;

  int total = 0;
  int passed = 0;

  typedef struct {
    logic g, f, ci, cw, ei;
    logic [31:0] rxd;
    logic [3:0]  rxk;
    logic [3:0]  st;
    logic        oci, ocw, oei;
    logic [31:0] txd;
    logic [3:0]  txk;
    logic        lu;
  } vec_t;

  vec_t walk[16];
  vec_t intr[6];

  sata_oob_ctrl #(.RETRY_TIMEOUT(20'd1000), .LOSS_CYCLES(16), .NONALIGN_REQ(3)) dut (
    .clk(clk), .rst(rst), .gt_reset_done(gt_reset_done), .txcomfinish(txcomfinish),
    .rxcominitdet(rxcominitdet), .rxcomwakedet(rxcomwakedet), .rxelecidle(rxelecidle),
    .rxdata(rxdata), .rxcharisk(rxcharisk), .txcominit(txcominit), .txcomwake(txcomwake),
    .txelecidle(txelecidle), .txdata(txdata), .txcharisk(txcharisk), .data_valid(data_valid),
    .link_up(link_up), .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic g, f, ci, cw, ei, input logic [31:0] rxd,
                              input logic [3:0] rxk, input logic [3:0] st, input logic oci, ocw, oei,
                              input logic [31:0] txd, input logic [3:0] txk, input logic lu);
    vec_t v;
    v.g = g; v.f = f; v.ci = ci; v.cw = cw; v.ei = ei; v.rxd = rxd; v.rxk = rxk;
    v.st = st; v.oci = oci; v.ocw = ocw; v.oei = oei; v.txd = txd; v.txk = txk; v.lu = lu;
    return v;
  endfunction

  task automatic drive(input logic g, f, ci, cw, ei, input logic [31:0] d, input logic [3:0] k);
    @(negedge clk);
    gt_reset_done = g; txcomfinish = f; rxcominitdet = ci; rxcomwakedet = cw;
    rxelecidle = ei; rxdata = d; rxcharisk = k;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] st, input logic ci, cw, ei,
                       input logic [31:0] d, input logic [3:0] k, input logic lu);
    logic [44:0] got, exp;
    got = {state_o, txcominit, txcomwake, txelecidle, txdata, txcharisk, data_valid, link_up};
    exp = {st, ci, cw, ei, d, k, lu, lu};
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h (state,cominit,comwake,elecidle,data,isk,dv,lu)", name, got, exp);
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic apply(input vec_t v, input string name);
    drive(v.g, v.f, v.ci, v.cw, v.ei, v.rxd, v.rxk);
    check(name, v.st, v.oci, v.ocw, v.oei, v.txd, v.txk, v.lu);
  endtask

  task automatic to_send_align();
    drive(1, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, ALIGN, 4'b0001);
    check_val("reach_send_align", int'(state_o), 7);
  endtask

  task automatic to_ready();
    to_send_align();
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, SYNC, 4'b0001);
    check_val("reach_ready", int'(state_o), 8);
  endtask

  initial begin
    int n;
    int pulses;

    walk[0]  = mk(1,0,0,0,0, 0, 0,            1, 1,0,1, 0, 0, 0);
    walk[1]  = mk(1,0,0,0,0, 0, 0,            1, 0,0,1, 0, 0, 0);
    walk[2]  = mk(1,1,0,0,0, 0, 0,            2, 0,0,1, 0, 0, 0);
    walk[3]  = mk(1,0,1,0,0, 0, 0,            3, 0,1,1, 0, 0, 0);
    walk[4]  = mk(1,0,0,0,0, 0, 0,            3, 0,0,1, 0, 0, 0);
    walk[5]  = mk(1,1,0,0,0, 0, 0,            4, 0,0,1, 0, 0, 0);
    walk[6]  = mk(1,0,0,1,0, 0, 0,            5, 0,0,1, 0, 0, 0);
    walk[7]  = mk(1,0,0,1,0, 0, 0,            5, 0,0,1, 0, 0, 0);
    walk[8]  = mk(1,0,0,0,0, 0, 0,            6, 0,0,0, D102, 4'b0000, 0);
    walk[9]  = mk(1,0,0,0,0, D102, 4'b0000,   6, 0,0,0, D102, 4'b0000, 0);
    walk[10] = mk(1,0,0,0,0, ALIGN, 4'b0001,  7, 0,0,0, ALIGN, 4'b0001, 0);
    walk[11] = mk(1,0,0,0,0, ALIGN, 4'b0001,  7, 0,0,0, ALIGN, 4'b0001, 0);
    walk[12] = mk(1,0,0,0,0, SYNC, 4'b0001,   7, 0,0,0, ALIGN, 4'b0001, 0);
    walk[13] = mk(1,0,0,0,0, SYNC, 4'b0001,   7, 0,0,0, ALIGN, 4'b0001, 0);
    walk[14] = mk(1,0,0,0,0, SYNC, 4'b0001,   8, 0,0,0, SYNC, 4'b0001, 1);
    walk[15] = mk(1,0,0,0,0, SYNC, 4'b0001,   8, 0,0,0, SYNC, 4'b0001, 1);

    intr[0] = mk(1,0,0,0,0, SYNC, 4'b0001,    7, 0,0,0, ALIGN, 4'b0001, 0);
    intr[1] = mk(1,0,0,0,0, SYNC, 4'b0001,    7, 0,0,0, ALIGN, 4'b0001, 0);
    intr[2] = mk(1,0,0,0,0, ALIGN, 4'b0001,   7, 0,0,0, ALIGN, 4'b0001, 0);
    intr[3] = mk(1,0,0,0,0, SYNC, 4'b0001,    7, 0,0,0, ALIGN, 4'b0001, 0);
    intr[4] = mk(1,0,0,0,0, SYNC, 4'b0001,    7, 0,0,0, ALIGN, 4'b0001, 0);
    intr[5] = mk(1,0,0,0,0, SYNC, 4'b0001,    8, 0,0,0, SYNC, 4'b0001, 1);

    rst = 1'b1;
    gt_reset_done = 0; txcomfinish = 0; rxcominitdet = 0; rxcomwakedet = 0;
    rxelecidle = 0; rxdata = '0; rxcharisk = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_values", 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    check("idle_hold", 0, 0, 0, 1, 0, 0, 0);

    // Full bring-up: COMINIT answered ~100 cycles after txcomfinish.
    for (int i = 0; i < 3; i++) apply(walk[i], $sformatf("walk%0d", i));
    for (int i = 0; i < 99; i++) drive(1, 0, 0, 0, 0, 0, 0);
    check("wait_cominit_hold", 2, 0, 0, 1, 0, 0, 0);
    for (int i = 3; i < 16; i++) apply(walk[i], $sformatf("walk%0d", i));

    // Link loss: 15 idle cycles survive, 16 restart.
    for (int i = 0; i < 15; i++) drive(1, 0, 0, 0, 1, SYNC, 4'b0001);
    check("loss15_stays", 8, 0, 0, 0, SYNC, 4'b0001, 1);
    drive(1, 0, 0, 0, 0, SYNC, 4'b0001);
    check("loss_break", 8, 0, 0, 0, SYNC, 4'b0001, 1);
    for (int i = 0; i < 15; i++) drive(1, 0, 0, 0, 1, SYNC, 4'b0001);
    check("loss15_again", 8, 0, 0, 0, SYNC, 4'b0001, 1);
    drive(1, 0, 0, 0, 1, SYNC, 4'b0001);
    check("loss16_exit", 1, 1, 0, 1, 0, 0, 0);

    // ALIGN interrupting the non-ALIGN run.
    to_send_align();
    for (int i = 0; i < 6; i++) apply(intr[i], $sformatf("interrupt%0d", i));

    // COMINIT and elecidle together in READY: one COMRESET, one pulse.
    drive(1, 0, 1, 0, 1, SYNC, 4'b0001);
    check("coincident_exit", 1, 1, 0, 1, 0, 0, 0);
    pulses = 1;
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      if (txcominit) pulses++;
    end
    check_val("single_cominit", pulses, 1);
    check("comreset_hold", 1, 0, 0, 1, 0, 0, 0);

    // Retry timeout, two rounds.
    for (int r = 0; r < 2; r++) begin
      drive(1, 1, 0, 0, 0, 0, 0);
      check($sformatf("retry_enter%0d", r), 2, 0, 0, 1, 0, 0, 0);
      n = 0;
      while (n < 1100 && !txcominit) begin
        drive(1, 0, 0, 0, 0, 0, 0);
        n++;
      end
      check_val($sformatf("retry_cycles%0d", r), n, 1000);
      check($sformatf("retry_pulse%0d", r), 1, 1, 0, 1, 0, 0, 0);
    end

    // Async reset in WAIT_COMWAKE.
    drive(1, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0);
    check_val("reach_wait_comwake", int'(state_o), 4);
    @(negedge clk);
    txcomfinish = 0;
    rst = 1'b1;
    #2;
    check("async_rst", 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_restart", 1, 1, 0, 1, 0, 0, 0);
    pulses = 1;
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      if (txcominit) pulses++;
    end
    check_val("rst_single_pulse", pulses, 1);

    // gt_reset_done drop beats a coincident COMINIT in READY.
    to_ready();
    drive(0, 0, 1, 0, 0, SYNC, 4'b0001);
    check("gtrd_drop", 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("gtrd_low_hold", 0, 0, 0, 1, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
